// File: rtl/e203_tohost_mon_pkg.sv
// Shared definitions for the E203 end-of-test tohost monitor:
// FSM state encoding, default tohost PC and counter widths.
package e203_tohost_mon_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_ENDING,
        ST_QUIESCE,
        ST_DONE,
        ST_TIMEOUT
    } mon_state_e;

    localparam logic [31:0] DEFAULT_TOHOST_PC = 32'h8000_0086;

    // Counter widths; each counter saturates at all-ones of its width.
    localparam int unsigned CYCLE_CNT_W = 32;
    localparam int unsigned INSTR_CNT_W = 32;
    localparam int unsigned HIT_CNT_W   = 8;

endpackage

// File: rtl/e203_sat_cnt.sv
// Parameterized-width up counter with enable and synchronous clear.
// Holds at all-ones instead of wrapping.
module e203_sat_cnt #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    // Count up on enable, stop at the maximum value.
    // NOTE: reset is sampled on the clock edge only, so rst_n is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/e203_tohost_monitor.sv
// End-of-test monitor on the E203 commit stream.
// Counts cycles and dispatches, detects retirement of the tohost-write
// instruction, waits for interrupt activity to settle and latches pass/fail
// from x3. Optional watchdog built when E203_TOHOST_MON_TIMEOUT_EN is defined.
module e203_tohost_monitor
    import e203_tohost_mon_pkg::*;
#(
    parameter int unsigned               PC_SIZE        = 32,
    parameter int unsigned               XLEN           = 32,
    parameter logic [PC_SIZE-1:0]        TOHOST_PC      = PC_SIZE'(DEFAULT_TOHOST_PC),
    parameter int unsigned               HIT_TARGET     = 8,
    parameter logic [CYCLE_CNT_W-1:0]    TIMEOUT_CYCLES = 32'd10_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmt_valid,
    input  logic [PC_SIZE-1:0]     cmt_pc,
    input  logic                   i_valid,
    input  logic                   i_ready,
    input  logic [XLEN-1:0]        x3,
    input  logic                   irq_busy,
    output logic [CYCLE_CNT_W-1:0] cycle_count,
    output logic [INSTR_CNT_W-1:0] instr_count,
    output logic [CYCLE_CNT_W-1:0] end_cycle,
    output logic [HIT_CNT_W-1:0]   hit_cnt,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout
);

    mon_state_e state;

    logic hit;
    logic last_hit;
    logic instr_en;
    logic hit_en;

    assign hit      = cmt_valid && (cmt_pc == TOHOST_PC);
    // This hit brings the count to the target (hit_cnt is still below it in RUN/ENDING).
    assign last_hit = hit && (hit_cnt == HIT_CNT_W'(HIT_TARGET - 1));
    assign instr_en = i_valid && i_ready && (state == ST_RUN);
    assign hit_en   = hit && (state != ST_DONE) && (state != ST_TIMEOUT);

    e203_sat_cnt #(.WIDTH(CYCLE_CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (1'b1),
        .cnt   (cycle_count)
    );

    e203_sat_cnt #(.WIDTH(INSTR_CNT_W)) u_instr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (instr_en),
        .cnt   (instr_count)
    );

    e203_sat_cnt #(.WIDTH(HIT_CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (hit_en),
        .cnt   (hit_cnt)
    );

`ifdef E203_TOHOST_MON_TIMEOUT_EN
    logic wd_expire;
    logic timeout_q;

    assign wd_expire = (cycle_count == TIMEOUT_CYCLES - 1'b1);
    assign timeout   = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // End-of-test FSM with registered done/pass and the first-hit cycle stamp.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            done      <= 1'b0;
            pass      <= 1'b0;
            end_cycle <= '0;
`ifdef E203_TOHOST_MON_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            if ((state == ST_RUN) && hit) begin
                end_cycle <= cycle_count;
            end

            case (state)
                ST_RUN, ST_ENDING: begin
                    if (hit) begin
                        state <= last_hit ? ST_QUIESCE : ST_ENDING;
                    end
                end
                ST_QUIESCE: begin
                    if (!irq_busy) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        pass  <= (x3 == XLEN'(1));
                    end
                end
                default: begin
                end
            endcase

`ifdef E203_TOHOST_MON_TIMEOUT_EN
            // Watchdog overrides the normal flow, except a completion in the same cycle.
            if (wd_expire &&
                ((state == ST_RUN) || (state == ST_ENDING) ||
                 ((state == ST_QUIESCE) && irq_busy))) begin
                state     <= ST_TIMEOUT;
                done      <= 1'b1;
                pass      <= 1'b0;
                timeout_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_e203_tohost_monitor.sv
// Self-checking bench for e203_tohost_monitor. Stimulus pushes the expected
// next-cycle observation into a queue; a negedge monitor pops and compares.
module tb_e203_tohost_monitor;

    localparam logic [31:0] TOHOST     = 32'h8000_0086;
    localparam int          HIT_TARGET = 8;
    localparam logic [31:0] TO_CYCLES  = 32'd100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmt_valid = 1'b0;
    logic [31:0] cmt_pc = '0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [31:0] x3 = '0;
    logic        irq_busy = 1'b0;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
    logic [31:0] end_cycle;
    logic [7:0]  hit_cnt;
    logic        done;
    logic        pass;
    logic        timeout;

    e203_tohost_monitor #(
        .PC_SIZE        (32),
        .XLEN           (32),
        .TOHOST_PC      (TOHOST),
        .HIT_TARGET     (HIT_TARGET),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmt_valid   (cmt_valid),
        .cmt_pc      (cmt_pc),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .x3          (x3),
        .irq_busy    (irq_busy),
        .cycle_count (cycle_count),
        .instr_count (instr_count),
        .end_cycle   (end_cycle),
        .hit_cnt     (hit_cnt),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] instr;
        logic [31:0] endc;
        logic [7:0]  hits;
        logic        done;
        logic        pass;
        logic        to;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a test's story told in totals rather than states.
    logic [31:0] m_cyc;
    logic [31:0] m_instr;
    logic [31:0] m_end;
    int          m_hits;
    bit          m_first;
    bit          m_fin;
    bit          m_pass;
    bit          m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.cyc   = m_cyc;
        o.instr = m_instr;
        o.endc  = m_end;
        o.hits  = 8'(m_hits);
        o.done  = m_fin;
        o.pass  = m_pass;
        o.to    = m_to;
        return o;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_tick();
        bit h;
        bit target_met;
        if (!rst_n) begin
            m_cyc = 0; m_instr = 0; m_end = 0; m_hits = 0;
            m_first = 0; m_fin = 0; m_pass = 0; m_to = 0;
        end else begin
            h = cmt_valid && (cmt_pc == TOHOST);
            if (!m_fin) begin
                target_met = (m_hits >= HIT_TARGET);
                if (!m_first && i_valid && i_ready && m_instr != 32'hFFFF_FFFF) m_instr++;
                if (h) begin
                    if (!m_first) begin
                        m_first = 1;
                        m_end   = m_cyc;
                    end
                    if (m_hits < 255) m_hits++;
                end
                if (target_met && !irq_busy) begin
                    m_fin  = 1;
                    m_pass = (x3 == 32'd1);
                end
`ifdef E203_TOHOST_MON_TIMEOUT_EN
                else if (m_cyc == TO_CYCLES - 1) begin
                    m_fin  = 1;
                    m_pass = 0;
                    m_to   = 1;
                end
`endif
            end
            if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
        end
    endtask

    // One clock: model the edge, clock the DUT, queue what the DUT must show.
    task automatic step();
        model_tick();
        @(posedge clk);
        exp_q.push_back(model_obs());
        #1;
    endtask

    // Monitor: compares every queued observation half a cycle after its edge.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{cycle_count, instr_count, end_cycle, hit_cnt, done, pass, timeout};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL obs: got cyc=%0d instr=%0d end=%0d hits=%0d done=%0b pass=%0b to=%0b expected cyc=%0d instr=%0d end=%0d hits=%0d done=%0b pass=%0b to=%0b",
                             a.cyc, a.instr, a.endc, a.hits, a.done, a.pass, a.to,
                             e.cyc, e.instr, e.endc, e.hits, e.done, e.pass, e.to);
                end
            end
        end
    end

    task automatic idle_inputs();
        cmt_valid = 0; cmt_pc = 32'h8000_0001; i_valid = 0; i_ready = 0; irq_busy = 0;
    endtask

    task automatic rand_dispatch();
        i_valid = 1'($urandom);
        i_ready = 1'($urandom);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    // Eight hits with random gaps, optional irq hold-off, then a late extra hit.
    task automatic run_hits(input logic [31:0] x3_final, input int busy, input bit exp_pass);
        do_reset();
        x3 = x3_final;
        for (int h = 0; h < HIT_TARGET; h++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                idle_inputs(); rand_dispatch(); step();
            end
            rand_dispatch(); cmt_valid = 1; cmt_pc = TOHOST; step();
        end
        idle_inputs();
        check("done_after_target_hit", {31'd0, done}, 32'd0);
        check("hit_cnt_at_target", {24'd0, hit_cnt}, 32'd8);
        for (int k = 1; k <= busy + 1; k++) begin
            irq_busy = (k <= busy);
            x3 = (k == busy + 1) ? x3_final : 32'h5;
            rand_dispatch();
            step();
            if (k == busy) check("done_held_by_irq", {31'd0, done}, 32'd0);
        end
        irq_busy = 0;
        check("done_after_quiesce", {31'd0, done}, 32'd1);
        check("pass_value", {31'd0, pass}, {31'd0, exp_pass});
        cmt_valid = 1; cmt_pc = TOHOST; step();
        idle_inputs(); step();
        check("hit_cnt_after_done", {24'd0, hit_cnt}, 32'd8);
    endtask

    initial begin
        // Reset, run, then reset again mid-operation.
        do_reset();
        for (int c = 0; c < 50; c++) begin
            rand_dispatch();
            cmt_valid = 1'($urandom);
            cmt_pc    = 32'h8000_0001 | ($urandom & 32'hFE);
            step();
        end
        check("cycle_before_rerst", cycle_count, 32'd50);
        idle_inputs();
        rst_n = 0;
        step();
        check("rst_cycle_count", cycle_count, 32'd0);
        check("rst_instr_count", instr_count, 32'd0);
        check("rst_flags", {29'd0, done, pass, timeout}, 32'd0);
        rst_n = 1;

        // Dispatch counting around the first hit.
        for (int c = 0; c < 26; c++) begin
            idle_inputs();
            i_valid   = (c < 10) || (c >= 20);
            i_ready   = 1;
            cmt_valid = (c == 20);
            cmt_pc    = TOHOST;
            step();
        end
        idle_inputs();
        check("instr_count_first_hit", instr_count, 32'd11);
        check("end_cycle_first_hit", end_cycle, 32'd20);
        check("hit_cnt_first_hit", {24'd0, hit_cnt}, 32'd1);

        run_hits(32'd1, 0, 1'b1);
        run_hits(32'd2, 0, 1'b0);
        run_hits(32'd1, 5, 1'b1);

        // No hits: watchdog only when built in.
        do_reset();
        for (int c = 0; c < 105; c++) begin
            rand_dispatch(); step();
        end
`ifdef E203_TOHOST_MON_TIMEOUT_EN
        check("timeout_fired", {30'd0, timeout, done}, 32'd3);
`else
        check("timeout_absent", {30'd0, timeout, done}, 32'd0);
`endif
        check("pass_no_hits", {31'd0, pass}, 32'd0);

        // Random traffic with occasional resets.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                rst_n     = ($urandom_range(0, 99) != 0);
                rand_dispatch();
                cmt_valid = 1'($urandom);
                cmt_pc    = ($urandom_range(0, 3) == 0) ? TOHOST : 32'h8000_0010;
                x3        = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'd2;
                irq_busy  = ($urandom_range(0, 2) == 0);
                step();
            end
            rst_n = 1;
        end

        idle_inputs();
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
